// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers and read-mode type for sync_fifo_flags
package sync_fifo_pkg;

  // Read data timing of the FIFO build.
  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  // Pointer width for a power-of-two depth.
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Level width: one extra bit so that DEPTH itself is representable.
  function automatic int fifo_lw(input int depth);
    return fifo_aw(depth) + 1;
  endfunction

`ifdef SYNC_FIFO_FWFT_EN
  localparam rd_mode_e RD_MODE = RD_FWFT;
`else
  localparam rd_mode_e RD_MODE = RD_STD;
`endif

endpackage

// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer bundle of the flagged synchronous FIFO
interface sync_fifo_flags_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LW = fifo_lw(DEPTH);

  logic             sync_clr;
  logic             clr_err;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  // Side that uses the FIFO.
  modport master (
    output sync_clr, clr_err, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  // The FIFO itself.
  modport slave (
    input  sync_clr, clr_err, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - register array, one synchronous write port and one asynchronous read port
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [fifo_aw(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [fifo_aw(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - flagged synchronous FIFO; SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_flags_if.slave  bus
);
  localparam int AW = fifo_aw(DEPTH);
  localparam int LW = fifo_lw(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] ram_rdata;

  // Flags decode straight from the registered level.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Acceptance uses start-of-cycle state; a flush swallows both requests.
  assign wr_ok = bus.wr_en & ~full  & ~bus.sync_clr;
  assign rd_ok = bus.rd_en & ~empty & ~bus.sync_clr;

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  // Next pointers, level and sticky error state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (bus.sync_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // A new error in the same cycle as clr_err survives the clear.
    ovf_d = (ovf_q & ~bus.clr_err) | (bus.wr_en & full  & ~bus.sync_clr);
    udf_d = (udf_q & ~bus.clr_err) | (bus.rd_en & empty & ~bus.sync_clr);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only acknowledges it.
  assign bus.rd_data  = ram_rdata;
  assign bus.rd_valid = ~empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Registered read: data captured on an accepted pop, otherwise held.
  always_comb begin
    rd_valid_d = rd_ok;
    rd_data_d  = rd_ok ? ram_rdata : rd_data_q;
  end

  // Read output register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= LW'(AF_THRESH));
  assign bus.almost_empty = (level_q <= LW'(AE_THRESH));
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // In fall-through mode the valid qualifier must track occupancy exactly.
  a_fwft_valid : assert property (@(posedge clk) disable iff (reset)
    (RD_MODE != RD_FWFT) || (bus.rd_valid == ~bus.empty));
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags
module tb_sync_fifo_flags;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       m_rv  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    chk("level", 32'(bus.level), mdl.size());
    chk("full", 32'(bus.full), 32'(mdl.size() == D));
    chk("empty", 32'(bus.empty), 32'(mdl.size() == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(mdl.size() >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mdl.size() <= AE));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("rd_valid", 32'(bus.rd_valid), FWFT ? 32'(mdl.size() != 0) : 32'(m_rv));
  endtask

  // One clock of stimulus; model updated from start-of-cycle state.
  task automatic step(input logic we, input logic [7:0] wd, input logic re,
                      input logic clr = 1'b0, input logic ce = 1'b0);
    logic full_m, empty_m, wok, rok;
    full_m  = (mdl.size() == D);
    empty_m = (mdl.size() == 0);
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.rd_en    = re;
    bus.sync_clr = clr;
    bus.clr_err  = ce;
    if (clr) begin
      mdl.delete();
      m_ovf = m_ovf & ~ce;
      m_udf = m_udf & ~ce;
      m_rv  = 1'b0;
    end else begin
      wok = we & ~full_m;
      rok = re & ~empty_m;
      if (rok) exp_q.push_back(mdl.pop_front());
      if (wok) mdl.push_back(wd);
      m_ovf = (m_ovf & ~ce) | (we & full_m);
      m_udf = (m_udf & ~ce) | (re & empty_m);
      m_rv  = rok;
    end
    @(posedge clk);
    #1;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.sync_clr = 1'b0;
    bus.clr_err  = 1'b0;
    check_flags();
  endtask

  // Monitor: each presented word is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.rd_valid && (!FWFT || bus.rd_en)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h expected no word at %0t", bus.rd_data, $time);
      end else begin
        chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    bus.sync_clr = 1'b0; bus.clr_err = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_udf", 32'(bus.underflow), 0);
    if (!FWFT) begin
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
    end
    @(posedge clk); #1 reset = 1'b0;

    // Fill and drain, with overflow/underflow at the ends.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_level", 32'(bus.level), 16);
    chk("fill_full", 32'(bus.full), 1);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(bus.empty), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_set", 32'(bus.underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_err_ovf", 32'(bus.overflow), 0);
    chk("clr_err_udf", 32'(bus.underflow), 0);

    // Simultaneous read+write at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    step(1'b1, 8'h25, 1'b1);
    step(1'b1, 8'h26, 1'b1);
    chk("rw_level5", 32'(bus.level), 5);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous read+write at full, then at empty.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    chk("rw_full_level", 32'(bus.level), 15);
    chk("rw_full_ovf", 32'(bus.overflow), 1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b1);
    chk("rw_empty_level", 32'(bus.level), 1);
    chk("rw_empty_udf", 32'(bus.underflow), 1);
    chk("rw_empty_ovf_cleared", 32'(bus.overflow), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Wrap-around: 40 paired operations at level 3.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h83 + 8'(i), 1'b1);
    chk("wrap_level", 32'(bus.level), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Flush at level 9 with a concurrent write.
    for (int i = 0; i < 9; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    chk("flush_level", 32'(bus.level), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("flush_write_ignored", 32'(bus.level), 0);

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft_valid", 32'(bus.rd_valid), 1);
    chk("fwft_data", 32'(bus.rd_data), 32'h A5);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_valid", 32'(bus.rd_valid), 0);
    chk("fwft_pop_empty", 32'(bus.empty), 1);
`endif

    // Reset asserted in the middle of a burst.
    step(1'b1, 8'hD0, 1'b0);
    step(1'b1, 8'hD1, 1'b0);
    step(1'b1, 8'hD2, 1'b1);
    bus.wr_en = 1'b1; bus.wr_data = 8'hD3;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_level", 32'(bus.level), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
    if (!FWFT) chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
    mdl.delete(); exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
    bus.wr_en = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    check_flags();

    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
